// File: rtl/vld_cpu86_exec_trace_buffer.sv
// vld_cpu86_exec_trace_buffer: circular capture buffer for exec-stage snapshots with op/code trigger and freeze.
// Define VLD_TRACE_TIMESTAMP_EN to prepend a 32-bit capture-cycle timestamp to every entry.
module vld_cpu86_exec_trace_buffer #(
  parameter int NUM_REGS = 10,
  parameter int REG_W = 16,
  parameter int OP_W = 5,
  parameter int CODE_W = 4,
  parameter int DEPTH = 64,
  parameter int POST_TRIG = 8,
`ifdef VLD_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 32 + OP_W + CODE_W + NUM_REGS*REG_W
`else
  localparam int ENTRY_W = OP_W + CODE_W + NUM_REGS*REG_W
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vld_valid,
  input  logic [OP_W-1:0]            vld_op,
  input  logic [CODE_W-1:0]          vld_code,
  input  logic [NUM_REGS*REG_W-1:0]  vld_regs,
  input  logic                       cfg_wrap,
  input  logic                       trig_en,
  input  logic [OP_W-1:0]            trig_op,
  input  logic [CODE_W-1:0]          trig_code,
  input  logic                       clear,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                lost_cnt,
  output logic [1:0]                 state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(POST_TRIG + 2);
  typedef enum logic [1:0] {ARMED = 2'd0, TRIGGERED = 2'd1, FROZEN = 2'd2} state_t;
  state_t state, state_n;
  logic [PW-1:0] post, post_n;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_data;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic capture, pop, full, match, wr_en, drop, rd_adv;
  assign capture = vld_valid & (state != FROZEN);
  assign rd_valid = level != '0;
  assign pop = rd_valid & rd_ready;
  assign full = level[AW];
  assign match = trig_en & (vld_op == trig_op) & (vld_code == trig_code);
  assign wr_en = capture & (~full | pop | cfg_wrap);
  assign drop = capture & full & ~pop;
  // a wrapping overwrite retires the oldest entry exactly like a pop
  assign rd_adv = pop | (drop & cfg_wrap);
  assign rd_data = mem[rd_ptr];
  assign state_o = state;
`ifdef VLD_TRACE_TIMESTAMP_EN
  logic [31:0] ts;
  always_ff @(posedge clk) ts <= (reset | clear) ? '0 : ts + 32'd1;
  assign wr_data = {ts, vld_op, vld_code, vld_regs};
`else
  assign wr_data = {vld_op, vld_code, vld_regs};
`endif
  always_comb begin
    state_n = state;
    post_n = post;
    if (state == ARMED && capture && match) begin
      post_n = PW'(POST_TRIG);
      state_n = (POST_TRIG == 0) ? FROZEN : TRIGGERED;
    end else if (state == TRIGGERED && capture) begin
      post_n = post - PW'(1);
      state_n = (post == PW'(1)) ? FROZEN : TRIGGERED;
    end
  end
  always_ff @(posedge clk) begin
    if (reset | clear) begin
      state <= ARMED;
      post <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      lost_cnt <= '0;
    end else begin
      state <= state_n;
      post <= post_n;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_adv);
      level <= level + (AW+1)'(wr_en & ~rd_adv) - (AW+1)'(rd_adv & ~wr_en);
      lost_cnt <= lost_cnt + 16'(drop & (lost_cnt != 16'hFFFF));
    end
  end
  always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= wr_data;
endmodule

// File: tb/tb_vld_cpu86_exec_trace_buffer.sv
// tb_vld_cpu86_exec_trace_buffer: directed and random stimulus against a queue-based reference model.
// The monitor pops expected entries whenever the consumer accepts one and compares rd_data.
module tb_vld_cpu86_exec_trace_buffer;
  localparam int NUM_REGS = 10, REG_W = 16, OP_W = 5, CODE_W = 4, DEPTH = 64, POST_TRIG = 8;
  localparam int RW = NUM_REGS*REG_W;
`ifdef VLD_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 32 + OP_W + CODE_W + RW;
`else
  localparam int ENTRY_W = OP_W + CODE_W + RW;
`endif
  logic clk = 0, reset = 1, vld_valid = 0, cfg_wrap = 0, trig_en = 0, clear = 0, rd_ready = 0;
  logic [OP_W-1:0] vld_op = '0, trig_op = '0;
  logic [CODE_W-1:0] vld_code = '0, trig_code = '0;
  logic [RW-1:0] vld_regs = '0;
  logic rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] lost_cnt;
  logic [1:0] state_o;

  vld_cpu86_exec_trace_buffer #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .OP_W(OP_W), .CODE_W(CODE_W),
    .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .reset(reset), .vld_valid(vld_valid), .vld_op(vld_op), .vld_code(vld_code),
    .vld_regs(vld_regs), .cfg_wrap(cfg_wrap), .trig_en(trig_en), .trig_op(trig_op),
    .trig_code(trig_code), .clear(clear), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .level(level), .lost_cnt(lost_cnt), .state_o(state_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit run = 0, popped = 0;
  logic [ENTRY_W-1:0] mq [$];
  int mlost = 0, mstate = 0, mpost = 0;
  logic [31:0] mts = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: buffer contents as a plain queue of at most DEPTH entries
  always @(posedge clk) begin
    if (reset || clear) begin
      mq.delete();
      mlost = 0;
      mstate = 0;
      mpost = 0;
      mts = 0;
    end else begin
      if (vld_valid && mstate != 2) begin
        logic [ENTRY_W-1:0] e;
`ifdef VLD_TRACE_TIMESTAMP_EN
        e = {mts, vld_op, vld_code, vld_regs};
`else
        e = {vld_op, vld_code, vld_regs};
`endif
        if (mq.size() + int'(popped) < DEPTH || popped) mq.push_back(e);
        else begin
          if (cfg_wrap) begin
            void'(mq.pop_front());
            mq.push_back(e);
          end
          if (mlost < 65535) mlost++;
        end
        if (mstate == 0 && trig_en && vld_op == trig_op && vld_code == trig_code) begin
          mpost = POST_TRIG;
          mstate = (POST_TRIG == 0) ? 2 : 1;
        end else if (mstate == 1) begin
          mpost--;
          if (mpost == 0) mstate = 2;
        end
      end
      mts = mts + 1;
    end
    popped = 0;
  end

  always @(negedge clk) if (run) begin
    chk("level", 64'(level), 64'(mq.size()));
    chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    chk("lost_cnt", 64'(lost_cnt), 64'(mlost));
    chk("state_o", 64'(state_o), 64'(mstate));
    if (rd_ready && mq.size() != 0) begin
      logic [ENTRY_W-1:0] exp;
      exp = mq.pop_front();
      popped = 1;
      n_chk++;
      if (rd_data === exp) n_pass++;
      else $display("FAIL rd_data: got %h expected %h at %0t", rd_data, exp, $time);
    end
  end

  task automatic drive(bit v, logic [OP_W-1:0] op, logic [CODE_W-1:0] code, logic [RW-1:0] regs, bit rdy);
    vld_valid = v;
    vld_op = op;
    vld_code = code;
    vld_regs = regs;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1;
    drive(0, '0, '0, '0, 0);
    clear = 0;
  endtask

  function automatic logic [OP_W-1:0] op_of(logic [ENTRY_W-1:0] d);
    return d[RW+CODE_W +: OP_W];
  endfunction

  initial begin
    run = 1;
    drive(0, '0, '0, '0, 0);
    drive(0, '0, '0, '0, 0);
    reset = 0;
    chk("rst_level", 64'(level), 0);
    chk("rst_state", 64'(state_o), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_lost", 64'(lost_cnt), 0);
    // three beats then in-order readout
    for (int i = 1; i <= 3; i++) drive(1, OP_W'(i), '0, RW'(i), 0);
    drive(0, '0, '0, '0, 0);
    chk("t1_level", 64'(level), 3);
    for (int i = 1; i <= 3; i++) begin
      chk("t1_op", 64'(op_of(rd_data)), 64'(i));
      drive(0, '0, '0, '0, 1);
    end
    chk("t1_level_end", 64'(level), 0);
    chk("t1_rd_valid_end", 64'(rd_valid), 0);
    // overwrite-oldest mode
    do_clear();
    cfg_wrap = 1;
    for (int i = 0; i < 70; i++) drive(1, OP_W'(i), '0, RW'(i), 0);
    chk("wrap_level", 64'(level), 64);
    chk("wrap_lost", 64'(lost_cnt), 6);
    chk("wrap_first", 64'(rd_data[15:0]), 6);
    drive(1, '0, '0, RW'(70), 1);
    chk("fullpop_level", 64'(level), 64);
    chk("fullpop_lost", 64'(lost_cnt), 6);
    for (int i = 0; i < 64; i++) drive(0, '0, '0, '0, 1);
    chk("wrap_drained", 64'(level), 0);
    // drop-new mode
    do_clear();
    cfg_wrap = 0;
    for (int i = 0; i < 70; i++) drive(1, OP_W'(i), '0, RW'(i), 0);
    chk("drop_lost", 64'(lost_cnt), 6);
    chk("drop_first", 64'(rd_data[15:0]), 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("drop_last", 64'(rd_data[15:0]), 63);
      drive(0, '0, '0, '0, 1);
    end
    // trigger with post-trigger countdown
    do_clear();
    trig_en = 1;
    trig_op = 5;
    trig_code = 2;
    for (int i = 0; i < 20; i++)
      drive(1, (i == 4) ? OP_W'(5) : OP_W'(i % 4), (i == 4) ? CODE_W'(2) : '0, RW'(i), 0);
    chk("trig_level", 64'(level), 13);
    chk("trig_state", 64'(state_o), 2);
    do_clear();
    chk("trig_clr_level", 64'(level), 0);
    chk("trig_clr_state", 64'(state_o), 0);
    // reset mid-countdown
    drive(1, OP_W'(5), CODE_W'(2), '0, 0);
    for (int i = 0; i < 3; i++) drive(1, '0, '0, RW'(i), 0);
    chk("mid_state", 64'(state_o), 1);
    reset = 1;
    drive(0, '0, '0, '0, 0);
    reset = 0;
    chk("mid_rst_level", 64'(level), 0);
    chk("mid_rst_state", 64'(state_o), 0);
    chk("mid_rst_lost", 64'(lost_cnt), 0);
`ifdef VLD_TRACE_TIMESTAMP_EN
    begin
      logic [31:0] t0;
      trig_en = 0;
      for (int i = 0; i < 9; i++) drive(0, '0, '0, '0, 0);
      drive(1, OP_W'(1), '0, '0, 0);
      for (int i = 0; i < 4; i++) drive(0, '0, '0, '0, 0);
      drive(1, OP_W'(2), '0, '0, 0);
      t0 = rd_data[ENTRY_W-1 -: 32];
      drive(0, '0, '0, '0, 1);
      chk("ts_delta", 64'(rd_data[ENTRY_W-1 -: 32] - t0), 5);
      drive(0, '0, '0, '0, 1);
    end
`endif
    // randomized traffic against the model
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      if (c % 256 == 0) begin
        cfg_wrap = $urandom_range(0, 1);
        trig_en = $urandom_range(0, 1);
        trig_op = OP_W'($urandom_range(0, 7));
        trig_code = CODE_W'($urandom_range(0, 3));
      end
      clear = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 3) != 0, OP_W'($urandom_range(0, 7)), CODE_W'($urandom_range(0, 3)),
            RW'({$urandom, $urandom, $urandom, $urandom, $urandom}), $urandom_range(0, 2) == 0);
    end
    clear = 0;
    for (int i = 0; i < DEPTH + 2; i++) drive(0, '0, '0, '0, 1);
    chk("final_level", 64'(level), 0);
    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
